seg7_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver; the next generation of the board-level display driver that sits beside the CPU in the top level. Shows a DATA_W-bit value on DIGITS time-multiplexed digits, in hex or in unsigned decimal. Decimal uses a sequential double-dabble converter. Adds leading-zero blanking, decimal overflow indication and a load/busy handshake.

---
 rtl/seg7_scan_driver.sv | 175 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: hex or unsigned-decimal display of i_data,
// with a sequential double-dabble converter, leading-zero blanking and overflow dashes.
module seg7_scan_driver #(
  parameter int DIGITS   = 8,
  parameter int DATA_W   = 32,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              mode,
  input  logic              blank_lz,
  input  logic [DATA_W-1:0] i_data,
  output logic              busy,
  output logic [7:0]        o_seg,
  output logic [DIGITS-1:0] o_sel
);
  localparam int DW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DATA_W);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t            state, state_nxt;
  logic              load_hex, load_dec, conv_done;
  logic [DW-1:0]     disp_nib;
  logic              disp_ovf;
  logic [DATA_W-1:0] sr;
  logic [DW-1:0]     bcd;
  logic              ovf_acc;
  logic [SW-1:0]     step_cnt;
  logic [DW:0]       dd;
  logic [CW-1:0]     scan_cnt;
  logic [IW-1:0]     idx;
  logic [3:0]        cur_nib;
  logic [7:0]        seg_nxt;
  logic [7:0]        seg_p1;
  logic [DIGITS-1:0] sel_p1;

  // One double-dabble step; bit DW of the result is the bit leaving the top nibble.
  function automatic logic [DW:0] dd_step(input logic [DW-1:0] b, input logic bit_in);
    logic [DW-1:0] adj;
    adj = b;
    for (int d = 0; d < DIGITS; d++) begin
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
    return {adj, bit_in};
  endfunction

  function automatic logic upper_zero(input logic [DW-1:0] nib, input logic [IW-1:0] i);
    logic z;
    z = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (d >= int'(i) && nib[4*d +: 4] != 4'd0) z = 1'b0;
    end
    return z;
  endfunction

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_hex  = 1'b0;
    load_dec  = 1'b0;
    conv_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (cs) begin
          if (mode) begin
            load_dec  = 1'b1;
            state_nxt = S_CONV;
          end else begin
            load_hex = 1'b1;
          end
        end
      end
      S_CONV: begin
        if (step_cnt == SW'(DATA_W - 1)) begin
          conv_done = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_CONV);
  assign dd   = dd_step(bcd, sr[DATA_W-1]);

  // Conversion stage: the final step is written straight into the display register.
  always_ff @(posedge clk) begin
    if (load_dec) begin
      sr       <= i_data;
      bcd      <= '0;
      ovf_acc  <= 1'b0;
      step_cnt <= '0;
    end else if (state == S_CONV) begin
      sr       <= sr << 1;
      bcd      <= dd[DW-1:0];
      ovf_acc  <= ovf_acc | dd[DW];
      step_cnt <= step_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_nib <= '0;
      disp_ovf <= 1'b0;
    end else if (load_hex) begin
      disp_nib <= DW'(i_data);
      disp_ovf <= 1'b0;
    end else if (conv_done) begin
      disp_nib <= dd[DW-1:0];
      disp_ovf <= ovf_acc | dd[DW];
    end
  end

  assign cur_nib = disp_nib[4*idx +: 4];

  always_comb begin
    seg_nxt = glyph(cur_nib);
    if (disp_ovf)
      seg_nxt = 8'hBF;
    else if (blank_lz && idx != '0 && upper_zero(disp_nib, idx))
      seg_nxt = 8'hFF;
  end

  // Output stage: one cycle behind the scan index and display register.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      seg_p1   <= 8'hFF;
      sel_p1   <= '1;
    end else begin
      if (scan_cnt == CW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      seg_p1 <= seg_nxt;
      sel_p1 <= ~(DIGITS'(1) << idx);
    end
  end

  assign o_seg = seg_p1;
  assign o_sel = sel_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random loads, checked every
// cycle against an arithmetic model of the displayed value and scan position.
module tb_seg7_scan_driver;
  localparam int DIGITS   = 8;
  localparam int DATA_W   = 32;
  localparam int SCAN_DIV = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cs = 1'b0;
  logic              mode = 1'b0;
  logic              blank_lz = 1'b0;
  logic [DATA_W-1:0] i_data = '0;
  logic              busy;
  logic [7:0]        o_seg;
  logic [DIGITS-1:0] o_sel;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_hi  = 0;

  seg7_scan_driver #(.DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .cs(cs), .mode(mode), .blank_lz(blank_lz),
    .i_data(i_data), .busy(busy), .o_seg(o_seg), .o_sel(o_sel)
  );

  always #5 clk = ~clk;

  logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: the digit values shown, overflow, pending decimal work, scan position.
  int          m_dig [DIGITS];
  bit          m_ovf;
  int          m_busy_left;
  int unsigned m_pend;
  int          m_pos;
  logic [7:0]  m_seg;
  logic [DIGITS-1:0] m_sel;
  logic        m_busy;
  logic [7:0]  seen_seg [DIGITS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic show_value(input int unsigned v, input bit dec);
    int unsigned r;
    r = v;
    m_ovf = dec && (v >= 32'd100000000);
    for (int k = 0; k < DIGITS; k++) begin
      if (dec) begin
        m_dig[k] = int'(r % 10);
        r = r / 10;
      end else begin
        m_dig[k] = int'(r & 15);
        r = r >> 4;
      end
    end
  endtask

  function automatic logic [7:0] exp_seg(input int i, input logic blank);
    bit all0;
    if (m_ovf) return 8'hBF;
    if (blank && i != 0) begin
      all0 = 1'b1;
      for (int k = i; k < DIGITS; k++) if (m_dig[k] != 0) all0 = 1'b0;
      if (all0) return 8'hFF;
    end
    return glyph_tab[m_dig[i]];
  endfunction

  task automatic model_edge();
    int i;
    if (rst) begin
      for (int k = 0; k < DIGITS; k++) m_dig[k] = 0;
      m_ovf       = 1'b0;
      m_busy_left = 0;
      m_pos       = 0;
      m_seg       = 8'hFF;
      m_sel       = '1;
    end else begin
      i     = m_pos / SCAN_DIV;
      m_sel = ~(DIGITS'(1) << i);
      m_seg = exp_seg(i, blank_lz);
      m_pos = (m_pos + 1) % (SCAN_DIV * DIGITS);
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) show_value(m_pend, 1'b1);
      end else if (cs) begin
        if (mode) begin
          m_busy_left = DATA_W;
          m_pend      = i_data;
        end else begin
          show_value(i_data, 1'b0);
        end
      end
    end
    m_busy = (m_busy_left > 0);
  endtask

  task automatic step(input logic r, input logic c, input logic m, input logic [31:0] d);
    rst = r; cs = c; mode = m; i_data = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("o_sel", o_sel, m_sel);
    chk("o_seg", o_seg, m_seg);
    chk("busy", busy, m_busy);
    if (busy === 1'b1) busy_hi++;
    for (int k = 0; k < DIGITS; k++) if (o_sel === ~(DIGITS'(1) << k)) seen_seg[k] = o_seg;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, $urandom);
  endtask

  task automatic frame_expect(input string tag, input logic [63:0] e);
    for (int k = 0; k < DIGITS; k++) chk($sformatf("%s_d%0d", tag, k), seen_seg[k], e[8*k +: 8]);
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_seg", o_seg, 8'hFF);
    chk("rst_sel", o_sel, 8'hFF);
    idle(40);
    frame_expect("idle", 64'hC0C0_C0C0_C0C0_C0C0);

    busy_hi = 0;
    step(1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
    idle(40);
    frame_expect("hex", 64'hA186_88A1_8386_868E);
    chk("hex_busy_len", busy_hi, 0);

    busy_hi = 0;
    step(1'b0, 1'b1, 1'b1, 32'd12345678);
    idle(70);
    chk("dec_busy_len", busy_hi, 32);
    frame_expect("dec", 64'hF9A4_B099_9282_F880);

    busy_hi = 0;
    step(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
    idle(70);
    chk("ovf_busy_len", busy_hi, 32);
    frame_expect("ovf", 64'hBFBF_BFBF_BFBF_BFBF);
    step(1'b0, 1'b1, 1'b1, 32'd99999999);
    idle(70);
    frame_expect("nines", 64'h9090_9090_9090_9090);

    blank_lz = 1'b1;
    step(1'b0, 1'b1, 1'b0, 32'h00000A05);
    idle(40);
    frame_expect("blank", 64'hFFFF_FFFF_FF88_C092);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    idle(40);
    frame_expect("zero", 64'hFFFF_FFFF_FFFF_FFC0);
    blank_lz = 1'b0;

    // Loads during busy, including on the edge where busy falls, must be dropped.
    step(1'b0, 1'b1, 1'b1, 32'd555);
    idle(4);
    step(1'b0, 1'b1, 1'b1, 32'd777);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 32'hAB);
    idle(23);
    step(1'b0, 1'b1, 1'b0, 32'hAB);
    chk("fall_busy", busy, 1'b0);
    idle(40);
    frame_expect("hs", 64'hC0C0_C0C0_C092_9292);

    step(1'b0, 1'b1, 1'b1, 32'd12345678);
    idle(9);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_seg", o_seg, 8'hFF);
    chk("abort_sel", o_sel, 8'hFF);
    idle(70);
    frame_expect("abort", 64'hC0C0_C0C0_C0C0_C0C0);

    for (int t = 0; t < 3000; t++) begin
      int unsigned kind;
      logic [31:0] d;
      kind = $urandom_range(0, 5);
      case (kind)
        0: d = $urandom;
        1: d = $urandom_range(0, 99999999);
        2: d = $urandom_range(0, 255);
        3: d = 32'd99999999;
        4: d = 32'd100000000;
        default: d = 32'd0;
      endcase
      if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
